// File: rtl/led_blink_driver_pkg.sv
// Shared types for the LED blink driver: FSM state encoding.
package led_blink_driver_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

endpackage

// File: rtl/led_blink_driver_sat_counter.sv
// Up/down counter that saturates at all-ones and latches a sticky overflow flag
// when an increment is refused. Used as the pending-event queue depth.
module sat_counter #(
  parameter int unsigned WIDTH = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [WIDTH-1:0] count_o,
  output logic             ovf_o
);

  logic [WIDTH-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;

  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q;
    // Simultaneous inc and dec cancel, so only one-sided requests change the count.
    if (inc_i && !dec_i) begin
      if (count_q == '1) ovf_d = 1'b1;
      else               count_d = count_q + 1'b1;
    end else if (dec_i && !inc_i && count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count_o = count_q;
  assign ovf_o   = ovf_q;

endmodule

// File: rtl/led_blink_driver.sv
// Turns single-cycle event strobes into queued LED blinks with minimum on/off
// times measured in prescaler CE ticks.
module led_blink_driver
  import led_blink_driver_pkg::*;
#(
  parameter int unsigned CNTR_WIDTH = 4,
  parameter int unsigned ON_TICKS   = 3,
  parameter int unsigned OFF_TICKS  = 2,
  parameter int unsigned PEND_WIDTH = 3
) (
  input  logic CLK,
  input  logic RST,
  input  logic CE,
  input  logic EVT_IN,
  output logic LED_OUT,
  output logic BUSY,
  output logic DONE_CEO,
  output logic OVF
);

  localparam logic [CNTR_WIDTH-1:0] ON_LAST  = CNTR_WIDTH'(ON_TICKS - 1);
  localparam logic [CNTR_WIDTH-1:0] OFF_LAST = CNTR_WIDTH'(OFF_TICKS - 1);

  state_e                  state_q, state_d;
  logic [CNTR_WIDTH-1:0]   timer_q, timer_d;
  logic                    led_q, led_d;
  logic                    done_q, done_d;
  logic                    dequeue;
  logic [PEND_WIDTH-1:0]   pend;

  sat_counter #(
    .WIDTH(PEND_WIDTH)
  ) u_pend (
    .clk_i  (CLK),
    .rst_i  (RST),
    .inc_i  (EVT_IN),
    .dec_i  (dequeue),
    .count_o(pend),
    .ovf_o  (OVF)
  );

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    dequeue = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // Starting a blink does not wait for CE, keeping the press-to-light latency at one clock.
        if (pend != '0) begin
          state_d = ST_ON;
          timer_d = '0;
          dequeue = 1'b1;
        end
      end
      ST_ON: begin
        if (CE) begin
          if (timer_q == ON_LAST) begin
            state_d = ST_GAP;
            timer_d = '0;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
      end
      ST_GAP: begin
        if (CE) begin
          if (timer_q == OFF_LAST) begin
            timer_d = '0;
            if (pend != '0) begin
              state_d = ST_ON;
              dequeue = 1'b1;
            end else begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        timer_d = '0;
      end
    endcase
    led_d = (state_d == ST_ON);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      led_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      led_q   <= led_d;
      done_q  <= done_d;
    end
  end

  assign LED_OUT  = led_q;
  assign DONE_CEO = done_q;
  assign BUSY     = (state_q != ST_IDLE) || (pend != '0);

endmodule

// File: tb/tb_led_blink_driver.sv
// Scoreboard bench: stimulus pushes expected blinks/done pulses, a monitor
// measures LED high/low run lengths and DONE pulses and compares in order.
module tb_led_blink_driver;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic CE  = 1'b1;
  logic EVT_IN = 1'b0;
  logic LED_OUT, BUSY, DONE_CEO, OVF;

  typedef struct {
    bit is_done;
    int on_len;
    int gap_len;  // -1: gap before this blink not checked
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  bit   ce_div = 1'b0;
  int   ce_cnt = 0;

  led_blink_driver #(
    .CNTR_WIDTH(4),
    .ON_TICKS  (3),
    .OFF_TICKS (2),
    .PEND_WIDTH(3)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .CE      (CE),
    .EVT_IN  (EVT_IN),
    .LED_OUT (LED_OUT),
    .BUSY    (BUSY),
    .DONE_CEO(DONE_CEO),
    .OVF     (OVF)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_blink(input int on_len, input int gap_len);
    exp_t e;
    e.is_done = 1'b0;
    e.on_len  = on_len;
    e.gap_len = gap_len;
    exp_q.push_back(e);
  endtask

  task automatic push_done();
    exp_t e;
    e.is_done = 1'b1;
    e.on_len  = 0;
    e.gap_len = -1;
    exp_q.push_back(e);
  endtask

  // Inputs change 1 time unit after the rising edge; CE optionally divided by 4.
  task automatic tick();
    @(posedge CLK);
    #1;
    if (ce_div) begin
      ce_cnt = (ce_cnt + 1) % 4;
      CE = (ce_cnt == 0);
    end
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || BUSY) && n < 400) begin
      tick();
      n++;
    end
    check({name, "_drain_timeout"}, int'(n < 400), 1);
    check({name, "_busy_after"}, int'(BUSY), 0);
    tick();
  endtask

  // Monitor
  initial begin
    bit   prev_led = 1'b0;
    int   on_run   = 0;
    int   low_run  = 0;
    int   rise_gap = 0;
    exp_t e;
    forever begin
      @(negedge CLK);
      if (RST) begin
        prev_led = 1'b0;
        on_run   = 0;
        low_run  = 0;
        continue;
      end
      if (LED_OUT) begin
        if (!prev_led) rise_gap = low_run;
        on_run++;
      end else begin
        if (prev_led) begin
          if (exp_q.size() == 0) begin
            check("unexpected_blink", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("blink_kind", int'(e.is_done), 0);
            if (!e.is_done) begin
              check("blink_on_len", on_run, e.on_len);
              if (e.gap_len >= 0) check("blink_gap_len", rise_gap, e.gap_len);
            end
          end
          on_run  = 0;
          low_run = 0;
        end
        low_run++;
      end
      if (DONE_CEO) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("done_kind", int'(e.is_done), 1);
        end
      end
      prev_led = LED_OUT;
    end
  end

  // Stimulus
  initial begin
    tick();
    tick();
    check("rst_led", int'(LED_OUT), 0);
    check("rst_busy", int'(BUSY), 0);
    check("rst_done", int'(DONE_CEO), 0);
    check("rst_ovf", int'(OVF), 0);
    RST = 1'b0;
    tick();

    // 1: single event, latency and drain
    push_blink(3, -1);
    push_done();
    EVT_IN = 1'b1;
    tick();
    EVT_IN = 1'b0;
    check("t1_lat_pre", int'(LED_OUT), 0);
    check("t1_busy_queued", int'(BUSY), 1);
    tick();
    check("t1_lat_post", int'(LED_OUT), 1);
    wait_drain("t1");

    // 2: three consecutive events -> back-to-back blinks
    push_blink(3, -1);
    push_blink(3, 2);
    push_blink(3, 2);
    push_done();
    EVT_IN = 1'b1;
    repeat (3) tick();
    EVT_IN = 1'b0;
    wait_drain("t2");
    check("t2_ovf", int'(OVF), 0);

    // 3: saturation while held in ON with CE low
    push_blink(13, -1);
    for (int i = 0; i < 7; i++) push_blink(3, 2);
    push_done();
    EVT_IN = 1'b1;
    tick();
    EVT_IN = 1'b0;
    tick();
    CE = 1'b0;
    EVT_IN = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i == 7) check("t3_ovf_at_full", int'(OVF), 0);
      if (i == 8) check("t3_ovf_on_drop", int'(OVF), 1);
    end
    EVT_IN = 1'b0;
    CE = 1'b1;
    wait_drain("t3");
    check("t3_ovf_sticky", int'(OVF), 1);

    // 4: CE one clock in four, aligned so dequeue lands on a CE edge
    push_blink(12, -1);
    push_blink(12, 8);
    push_done();
    ce_div = 1'b1;
    ce_cnt = 0;
    while (ce_cnt != 3) tick();
    CE = 1'b0;
    EVT_IN = 1'b1;
    tick();
    check("t4_lat_pre", int'(LED_OUT), 0);
    tick();
    EVT_IN = 1'b0;
    check("t4_lat_post", int'(LED_OUT), 1);
    wait_drain("t4");
    ce_div = 1'b0;
    CE = 1'b1;
    tick();

    // 5: event coincident with GAP->ON dequeue
    push_blink(3, -1);
    push_blink(3, 2);
    push_blink(3, 2);
    push_done();
    EVT_IN = 1'b1;
    tick();
    tick();
    EVT_IN = 1'b0;
    repeat (4) tick();
    EVT_IN = 1'b1;
    tick();
    EVT_IN = 1'b0;
    wait_drain("t5");

    // 6: async reset mid-ON drops the blink and the queue
    EVT_IN = 1'b1;
    repeat (3) tick();
    EVT_IN = 1'b0;
    tick();
    check("t6_led_before", int'(LED_OUT), 1);
    check("t6_ovf_before", int'(OVF), 1);
    #1;
    RST = 1'b1;
    #1;
    check("t6_rst_led", int'(LED_OUT), 0);
    check("t6_rst_busy", int'(BUSY), 0);
    check("t6_rst_ovf", int'(OVF), 0);
    check("t6_rst_done", int'(DONE_CEO), 0);
    tick();
    RST = 1'b0;
    repeat (20) tick();
    check("t6_led_after", int'(LED_OUT), 0);
    check("t6_busy_after", int'(BUSY), 0);
    check("t6_queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
